// File: rtl/binary_search_guesser.sv
// Binary-search guesser: drives given_number into a magnitude comparator and
// narrows [lo, hi] on each eq/gt/lt answer until the hidden value is found.
module binary_search_guesser #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          resp_valid,
    input  logic          eq,
    input  logic          gt,
    input  logic          lt,
    output logic [N-1:0]  given_number,
    output logic          guess_valid,
    output logic          done,
    output logic          found,
    output logic          error,
    output logic [CW-1:0] guess_count
);

    // lo/hi carry one extra bit so mid+1 / mid-1 never wrap
    localparam int unsigned LW = N + 1;
    localparam logic [LW-1:0] HI_INIT = LW'((1 << N) - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [LW-1:0] lo, lo_n;
    logic [LW-1:0] hi, hi_n;
    logic [LW-1:0] mid;
    logic [N-1:0]  given_number_n;
    logic          done_n, found_n, error_n;
    logic [CW-1:0] guess_count_n;

    // lo + hi never exceeds 2*(2^N-1), so the LW-bit sum cannot overflow
    assign mid         = (lo + hi) >> 1;
    assign guess_valid = (state == SEARCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lo           <= '0;
            hi           <= HI_INIT;
            given_number <= '0;
            done         <= 1'b0;
            found        <= 1'b0;
            error        <= 1'b0;
            guess_count  <= '0;
        end else begin
            state        <= state_n;
            lo           <= lo_n;
            hi           <= hi_n;
            given_number <= given_number_n;
            done         <= done_n;
            found        <= found_n;
            error        <= error_n;
            guess_count  <= guess_count_n;
        end
    end

    always_comb begin
        state_n        = state;
        lo_n           = lo;
        hi_n           = hi;
        given_number_n = given_number;
        done_n         = done;
        found_n        = found;
        error_n        = error;
        guess_count_n  = guess_count;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n        = SEARCH;
                    lo_n           = '0;
                    hi_n           = HI_INIT;
                    given_number_n = N'(HI_INIT >> 1);
                    guess_count_n  = '0;
                    done_n         = 1'b0;
                    found_n        = 1'b0;
                    error_n        = 1'b0;
                end
            end
            SEARCH: begin
                if (resp_valid) begin
                    if (guess_count != CNT_MAX) begin
                        guess_count_n = guess_count + CW'(1);
                    end
                    case ({eq, gt, lt})
                        3'b100: begin
                            found_n = 1'b1;
                            done_n  = 1'b1;
                            state_n = DONE;
                        end
                        3'b010: begin
                            // new lo = mid+1 exceeds hi exactly when mid == hi
                            if (mid >= hi) begin
                                error_n = 1'b1;
                                done_n  = 1'b1;
                                state_n = DONE;
                            end else begin
                                lo_n           = mid + LW'(1);
                                given_number_n = N'((mid + LW'(1) + hi) >> 1);
                            end
                        end
                        3'b001: begin
                            // new hi = mid-1 drops below lo exactly when mid == lo (covers mid == 0)
                            if (mid <= lo) begin
                                error_n = 1'b1;
                                done_n  = 1'b1;
                                state_n = DONE;
                            end else begin
                                hi_n           = mid - LW'(1);
                                given_number_n = N'((lo + mid - LW'(1)) >> 1);
                            end
                        end
                        default: begin
                            error_n = 1'b1;
                            done_n  = 1'b1;
                            state_n = DONE;
                        end
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_binary_search_guesser.sv
// Scoreboard bench for binary_search_guesser: stimulus queues hand-computed
// guess sequences and final results; a negedge monitor pops and compares.
module tb_binary_search_guesser;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          resp_valid;
    logic          eq, gt, lt;
    logic [N-1:0]  given_number;
    logic          guess_valid;
    logic          done;
    logic          found;
    logic          error;
    logic [CW-1:0] guess_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int found;
        int error;
        int cnt;
        int gn;
    } res_t;

    int   exp_g[$];
    res_t exp_r[$];

    binary_search_guesser #(.N(N), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .resp_valid   (resp_valid),
        .eq           (eq),
        .gt           (gt),
        .lt           (lt),
        .given_number (given_number),
        .guess_valid  (guess_valid),
        .done         (done),
        .found        (found),
        .error        (error),
        .guess_count  (guess_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each accepted guess and each completed search
    logic         done_q    = 1'b0;
    logic         prev_wait = 1'b0;
    logic [N-1:0] prev_gn   = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            prev_wait <= 1'b0;
        end else begin
            if (guess_valid && prev_wait)
                chk("hold_guess", int'(given_number), int'(prev_gn));
            if (guess_valid && resp_valid) begin
                if (exp_g.size() == 0) chk("unexpected_guess", int'(given_number), -1);
                else                   chk("guess", int'(given_number), exp_g.pop_front());
            end
            if (done && !done_q) begin
                if (exp_r.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    res_t r;
                    r = exp_r.pop_front();
                    chk("found", int'(found), r.found);
                    chk("error", int'(error), r.error);
                    chk("guess_count", int'(guess_count), r.cnt);
                    chk("final_number", int'(given_number), r.gn);
                    chk("found_error_exclusive", int'(found && error), 0);
                end
            end
            done_q    <= done;
            prev_wait <= guess_valid && !resp_valid;
            prev_gn   <= given_number;
        end
    end

    // mode: 0 honest comparator, 1 always gt, 2 always lt, 3 eq&gt
    task automatic run(input int hidden, input int mode, input int period, input int inject_at);
        bit fin;
        fin = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done) begin
                fin = 1'b1;
                break;
            end
            start      = (cyc == inject_at);
            resp_valid = ((cyc % period) == (period - 1));
            case (mode)
                0: begin
                    eq = (hidden == int'(given_number));
                    gt = (hidden >  int'(given_number));
                    lt = (hidden <  int'(given_number));
                end
                1:       {eq, gt, lt} = 3'b010;
                2:       {eq, gt, lt} = 3'b001;
                default: {eq, gt, lt} = 3'b110;
            endcase
            @(posedge clk); #1;
        end
        start        = 1'b0;
        resp_valid   = 1'b0;
        {eq, gt, lt} = 3'b000;
        if (!fin) chk("search_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", int'(done), 1);
        chk("guess_valid_low_in_done", int'(guess_valid), 0);
        chk("guesses_left", exp_g.size(), 0);
        chk("results_left", exp_r.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_given_number"}, int'(given_number), 0);
        chk({tag, "_guess_valid"}, int'(guess_valid), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_found"}, int'(found), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_guess_count"}, int'(guess_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        resp_valid   = 1'b0;
        {eq, gt, lt} = 3'b000;
        #3;
        chk_zero("reset");
        #10 rst_n = 1'b1;

        // hidden 127: found on the first guess
        exp_g = {127};
        exp_r.push_back('{1, 0, 1, 127});
        run(127, 0, 1, -1);

        // hidden 0
        exp_g = {127, 63, 31, 15, 7, 3, 1, 0};
        exp_r.push_back('{1, 0, 8, 0});
        run(0, 0, 1, -1);

        // hidden 255: maximum guess count
        exp_g = {127, 191, 223, 239, 247, 251, 253, 254, 255};
        exp_r.push_back('{1, 0, 9, 255});
        run(255, 0, 1, -1);

        // always gt: range exhausted after guess 255
        exp_g = {127, 191, 223, 239, 247, 251, 253, 254, 255};
        exp_r.push_back('{0, 1, 9, 255});
        run(0, 1, 1, -1);

        // always lt: range exhausted after guess 0
        exp_g = {127, 63, 31, 15, 7, 3, 1, 0};
        exp_r.push_back('{0, 1, 8, 0});
        run(0, 2, 1, -1);

        // hidden 200, sparse responses, start pulsed mid-search
        exp_g = {127, 191, 223, 207, 199, 203, 201, 200};
        exp_r.push_back('{1, 0, 8, 200});
        run(200, 0, 3, 4);

        // malformed eq&gt on the first response
        exp_g = {127};
        exp_r.push_back('{0, 1, 1, 127});
        run(200, 3, 1, -1);

        // async reset mid-search on hidden 100
        exp_g = {127, 63, 95};
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        resp_valid   = 1'b1;
        {eq, gt, lt} = 3'b001;
        @(posedge clk); #1 {eq, gt, lt} = 3'b010;
        @(posedge clk); #1 {eq, gt, lt} = 3'b010;
        @(posedge clk); #1;
        resp_valid   = 1'b0;
        {eq, gt, lt} = 3'b000;
        #1 rst_n = 1'b0;
        #1;
        chk_zero("abort");
        chk("abort_guesses_left", exp_g.size(), 0);
        #4 rst_n = 1'b1;

        // fresh search after abort: hidden 42
        exp_g = {127, 63, 31, 47, 39, 43, 41, 42};
        exp_r.push_back('{1, 0, 8, 42});
        run(42, 0, 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/binary_search_guesser.md
Name: binary_search_guesser

Overview:
- Sequential counterpart of the team's N-bit magnitude comparator.
- Drives given_number into the comparator and consumes its eq/gt/lt answer (comparator main_number holds the hidden value).
- Performs a binary search to find the hidden value, asserting one guess per accepted response.
- Reports the found value, the number of guesses used, and an error if the feedback is inconsistent or malformed.

Parameters:
- N, 8, width of the searched value; search range 0..2^N-1.
- CW, 4, width of guess_count; must hold N+1 (maximum guesses = N+1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a new search; sampled in IDLE and DONE only
- resp_valid  input  1  eq/gt/lt are valid for the current given_number
- eq  input  1  comparator: hidden == given_number
- gt  input  1  comparator: hidden > given_number (guess too low)
- lt  input  1  comparator: hidden < given_number (guess too high)
- given_number  output  N  current guess (registered)
- guess_valid  output  1  high while a guess awaits a response
- done  output  1  search finished; held until the next start
- found  output  1  with done: given_number equals the hidden value
- error  output  1  with done: inconsistent or non-one-hot feedback
- guess_count  output  CW  responses accepted in the current or last search

Behaviour:
- Reset (async, rst_n=0): state IDLE; given_number=0, guess_valid=0, done=0, found=0, error=0, guess_count=0, lo=0, hi=2^N-1.
- Internal lo/hi are N+1 bits wide so mid+1 and mid-1 never wrap. mid = (lo+hi)>>1, truncated to N bits for given_number.
- States: IDLE, SEARCH, DONE.
- IDLE, start=1: lo=0, hi=2^N-1, given_number=2^(N-1)-1 (127 for N=8), guess_count=0, done/found/error=0 -> SEARCH next cycle.
- SEARCH: guess_valid=1 combinationally from state. given_number is stable while resp_valid=0; the block waits indefinitely.
- Response acceptance: one response per clock edge where resp_valid=1. guess_count increments, saturating at 2^CW-1.
  - eq&~gt&~lt: found=1, done=1 -> DONE; given_number unchanged.
  - gt&~eq&~lt: lo=mid+1. If the new lo>hi: error=1, done=1 -> DONE. Else given_number=new mid, stay in SEARCH.
  - lt&~eq&~gt: hi=mid-1 (mid=0 gives hi=-1, i.e. lo>hi): error=1, done=1 -> DONE. Else given_number=new mid, stay in SEARCH.
  - Any other eq/gt/lt combination (zero or multiple set): error=1, done=1 -> DONE; given_number unchanged.
- Response latency: the new guess appears one cycle after the accepting edge. With resp_valid held high, the block issues one guess per cycle.
- start in SEARCH is ignored.
- DONE: guess_valid=0. done, found, error, given_number and guess_count are held. start=1 re-initialises exactly as from IDLE (done/found/error clear on that edge).
- found and error are never both 1.
- Reset asserted mid-search aborts immediately to the reset values above; no partial state survives.
- Consistent feedback always terminates with found=1 within N+1 accepted responses.

Test Plan:
- Hidden 127, start, resp_valid=1 -> first guess 127, eq; done=1, found=1, guess_count=1, given_number=127.
- Hidden 0 -> guesses 127,63,31,15,7,3,1,0; found=1, guess_count=8.
- Hidden 255 -> guesses 127,191,223,239,247,251,253,254,255; found=1, guess_count=9 (the maximum).
- Bench forces gt at every guess -> after guess 255, error=1, found=0, done=1, guess_count=9. Forcing lt at every guess -> after guess 0, error=1, guess_count=8.
- Hidden 200, resp_valid pulsed every 3rd cycle; start pulsed mid-search; eq&gt injected on a 2nd run -> first run: given_number holds while resp_valid=0, start ignored, found with guess_count=8. Second run: error=1 on the first response, given_number=127.
- rst_n dropped asynchronously mid-search (between edges) -> all outputs 0 immediately. Subsequent start on hidden 42 -> found=1 with fresh guess_count.
